// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, midpoint sampling.
// Emits each good byte with a 1-cycle strobe; flags bad stop bits.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk_50M,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_msg,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BRK
  } state_t;

  state_t          state;
  state_t          nxt;
  logic            sync1;
  logic            rx_s;
  logic [CW-1:0]   bit_cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic            mid_start;
  logic            bit_end;
  logic            load;
  logic            bad;

  assign mid_start = (bit_cnt == CW'(HALF_BIT - 1));
  assign bit_end   = (bit_cnt == CW'(CLKS_PER_BIT - 1));

  // two-flop synchronizer; idles high so reset never looks like a start
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // state register
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: begin
        if (!rx_s) nxt = S_START;
      end
      S_START: begin
        if (mid_start) nxt = rx_s ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_end && idx == 3'd7) nxt = S_STOP;
      end
      S_STOP: begin
        if (bit_end) nxt = rx_s ? S_IDLE : S_BRK;
      end
      S_BRK: begin
        if (rx_s) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  // output decode: stop-bit verdict and busy flag
  always_comb begin
    busy = (state != S_IDLE);
    load = (state == S_STOP) && bit_end && rx_s;
    bad  = (state == S_STOP) && bit_end && !rx_s;
  end

  // bit timer: restarts on every state change and at each bit boundary
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (nxt != state || bit_end ||
                 state == S_IDLE || state == S_BRK) begin
      bit_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + CW'(1);
    end
  end

  // data capture at each data-bit midpoint
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= 3'd0;
      shreg <= 8'h00;
    end else if (state == S_START) begin
      idx <= 3'd0;
    end else if (state == S_DATA && bit_end) begin
      shreg[idx] <= rx_s;
      idx        <= idx + 3'd1;
    end
  end

  // registered result and single-cycle strobes
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      rx_msg    <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= load;
      frame_err <= bad;
      if (load) rx_msg <= shreg;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: table-driven frames plus corner sequences.
// Scoreboard queue holds expected byte/err per frame.
module tb_uart_rx;

  logic       clk_50M = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] rx_msg;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int nvalid = 0;
  int nerr   = 0;

  typedef struct {
    logic [7:0] msg;
    bit         err;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    int         cpb;
    bit         stop;
    logic [7:0] exp_msg;
    bit         exp_err;
  } vec_t;

  exp_t sb[$];
  int   vt[$];
  vec_t tbl[5];

  uart_rx dut (
    .clk_50M  (clk_50M),
    .rst_n    (rst_n),
    .rx       (rx),
    .rx_msg   (rx_msg),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
  );

  always #10 clk_50M = ~clk_50M;

  bit prev_v = 1'b0;
  bit prev_e = 1'b0;

  always @(negedge clk_50M) begin
    exp_t e;
    cyc++;
    if (!rst_n) begin
      prev_v = 1'b0;
      prev_e = 1'b0;
    end else begin
      if (rx_valid || frame_err) begin
        checks++;
        if (rx_valid && frame_err) begin
          errors++;
          $display("FAIL both_pulses valid=%0b err=%0b req=exclusive",
                   rx_valid, frame_err);
        end
        checks++;
        if ((rx_valid && prev_v) || (frame_err && prev_e)) begin
          errors++;
          $display("FAIL pulse_width got=multi-cycle req=1 cycle");
        end
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse valid=%0b err=%0b msg=%h",
                   rx_valid, frame_err, rx_msg);
        end else begin
          e = sb.pop_front();
          checks++;
          if (frame_err !== e.err) begin
            errors++;
            $display("FAIL pulse_kind got_err=%0b req_err=%0b",
                     frame_err, e.err);
          end
          checks++;
          if (rx_msg !== e.msg) begin
            errors++;
            $display("FAIL rx_msg got=%h req=%h", rx_msg, e.msg);
          end
        end
        if (rx_valid) begin
          nvalid++;
          vt.push_back(cyc);
        end
        if (frame_err) nerr++;
      end
      prev_v = rx_valid;
      prev_e = frame_err;
    end
  end

  task automatic chk(input string nm, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d req=%0d", nm, got, req);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int cpb,
                            input bit stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_50M);
      rx = f[i];
      repeat (cpb - 1) @(negedge clk_50M);
    end
  endtask

  task automatic wait_drain(input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 6000) begin
      @(negedge clk_50M);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout got=%0d pending req=0", nm, sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk_50M);
    chk({nm, "_busy_low"}, int'(busy), 0);
  endtask

  initial begin
    #1_800_000;
    $display("FAIL watchdog got=timeout req=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int bcnt;
    logic [9:0] f;
    logic [7:0] atb [3];

    tbl[0] = '{8'h55, 434, 1'b1, 8'h55, 1'b0};
    tbl[1] = '{8'h00, 443, 1'b1, 8'h00, 1'b0};
    tbl[2] = '{8'hFF, 425, 1'b1, 8'hFF, 1'b0};
    tbl[3] = '{8'hC3, 434, 1'b0, 8'hFF, 1'b1};
    tbl[4] = '{8'h96, 434, 1'b1, 8'h96, 1'b0};

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk_50M);
    chk("rst_msg", int'(rx_msg), 0);
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_err", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk_50M);

    for (int i = 0; i < 5; i++) begin
      sb.push_back('{tbl[i].exp_msg, tbl[i].exp_err});
      send_frame(tbl[i].data, tbl[i].cpb, tbl[i].stop);
      rx = 1'b1;
      wait_drain($sformatf("vec%0d", i));
      repeat (50) @(negedge clk_50M);
    end

    vt.delete();
    sb.push_back('{8'h00, 1'b0});
    sb.push_back('{8'hFF, 1'b0});
    sb.push_back('{8'hA5, 1'b0});
    send_frame(8'h00, 434, 1'b1);
    send_frame(8'hFF, 434, 1'b1);
    send_frame(8'hA5, 434, 1'b1);
    wait_drain("b2b");
    chk("b2b_count", vt.size(), 3);
    if (vt.size() == 3) begin
      checks++;
      if (vt[1] - vt[0] < 4338 || vt[1] - vt[0] > 4342 ||
          vt[2] - vt[1] < 4338 || vt[2] - vt[1] > 4342) begin
        errors++;
        $display("FAIL b2b_spacing got=%0d,%0d req=4340+/-2",
                 vt[1] - vt[0], vt[2] - vt[1]);
      end
    end
    repeat (100) @(negedge clk_50M);

    n0 = nvalid + nerr;
    bcnt = 0;
    @(negedge clk_50M);
    rx = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 100) rx = 1'b1;
      if (busy) bcnt++;
      @(negedge clk_50M);
    end
    chk("glitch_pulses", nvalid + nerr, n0);
    checks++;
    if (bcnt == 0 || bcnt > 220) begin
      errors++;
      $display("FAIL glitch_busy got=%0d req=1..220", bcnt);
    end
    chk("glitch_busy_low", int'(busy), 0);

    sb.push_back('{8'hA5, 1'b1});
    send_frame(8'h3C, 434, 1'b0);
    repeat (1000) @(negedge clk_50M);
    chk("break_busy", int'(busy), 1);
    chk("break_msg", int'(rx_msg), 8'hA5);
    repeat (1000) @(negedge clk_50M);
    rx = 1'b1;
    repeat (50) @(negedge clk_50M);
    chk("break_exit_busy", int'(busy), 0);
    sb.push_back('{8'h81, 1'b0});
    send_frame(8'h81, 434, 1'b1);
    wait_drain("after_break");
    repeat (50) @(negedge clk_50M);

    f = {1'b1, 8'h7E, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_50M);
      rx = f[i];
      repeat (433) @(negedge clk_50M);
    end
    rx = f[5];
    repeat (200) @(negedge clk_50M);
    chk("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_msg", int'(rx_msg), 0);
    chk("mid_rst_valid", int'(rx_valid), 0);
    chk("mid_rst_err", int'(frame_err), 0);
    chk("mid_rst_busy", int'(busy), 0);
    rx = 1'b1;
    repeat (10) @(negedge clk_50M);
    rst_n = 1'b1;
    n0 = nvalid + nerr;
    repeat (500) @(negedge clk_50M);
    chk("post_rst_pulses", nvalid + nerr, n0);
    sb.push_back('{8'h12, 1'b0});
    send_frame(8'h12, 434, 1'b1);
    wait_drain("post_rst");

    atb[0] = 8'h41;
    atb[1] = 8'h54;
    atb[2] = 8'h42;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{atb[i], 1'b0});
      send_frame(atb[i], 434, 1'b1);
    end
    rx = 1'b1;
    wait_drain("atb");
    chk("total_valid", nvalid, 12);
    chk("total_err", nerr, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
